vga_stream_sched: RTL
=====================

# vga_stream_sched

Frame scheduler that sits between a 24-bit pixel stream source and the VGA output pins in the `p_clk` domain. It generates raster timing and locks the incoming stream to the raster at frame boundaries. It pulls exactly one pixel per active-area cycle through a valid/ready handshake. On underflow or frame misalignment it substitutes fill pixels and re-locks at the next frame.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- `V_ACTIVE`, 480, active lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- `SYNC_POL`, 0, asserted level of `VGA_HS` and `VGA_VS`
- `sys_clk`  in  1  pixel clock; one clock only
- `rst`  in  1  synchronous, active-high reset
- `pix_data`  in  24  RGB888 stream pixel
- `pix_sof`  in  1  marks the first pixel of a frame
- `pix_valid`  in  1  stream beat valid
- `pix_ready`  out  1  beat consumed when `pix_valid && pix_ready`
- `err_clr`  in  1  clears `underflow`
- `hcount` / `vcount`  out  12  raster position
- `VGA_HS` / `VGA_VS`  out  1  sync outputs
- `VGA_BLK`  out  1  1 = active video
- `VGA_RGB`  out  24  pixel output
- `frame_start`  out  1  one-cycle pulse at raster (0,0)
- `locked`  out  1  high while in state RUN
- `underflow`  out  1  sticky error flag

## Operation
- Raster counters:
  - `H_TOTAL` = sum of horizontal params (800); `V_TOTAL` = sum of vertical params (525).
  - `hcount` counts 0..H_TOTAL-1 and wraps to 0. On wrap, `vcount` increments, wrapping at V_TOTAL-1 → 0.
  - active = `hcount < H_ACTIVE && vcount < V_ACTIVE`.
  - HS asserted for `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
  - VS asserted for `vcount` in [490, 491].
- FSM states `WAIT_SOF` (reset state), `RUN`, `RESYNC`:
  - WAIT_SOF / RESYNC: `pix_ready = pix_valid && !pix_sof`, so non-SOF beats are dropped and an SOF beat is held at the head.
    - At raster (H_TOTAL-1, V_TOTAL-1), if `pix_valid && pix_sof`, go to RUN.
    - All active pixels in these states are fill.
  - RUN: `pix_ready = active`.
    - Active cycle with `!pix_valid`: output fill, set `underflow`, go to RESYNC.
    - Beat consumed with `pix_sof` at any position other than (0,0): output fill, set `underflow`, go to RESYNC, and drop that beat.
- RESYNC differs from WAIT_SOF only in being entered from RUN. It is kept distinct so coverage can separate the two.
- `underflow` is sticky. `err_clr` clears it. If a set and `err_clr` occur in the same cycle, set wins.
- `VGA_RGB` = 0 whenever `VGA_BLK` = 0.

## Timing
- Counters update every cycle.
- `VGA_HS`, `VGA_VS`, `VGA_BLK`, `VGA_RGB` and `frame_start` are registered from the counter state of the previous cycle: 1-cycle latency from `hcount`/`vcount`.
- `pix_ready` is combinational from FSM state and counters; no combinational path from `pix_valid`. A beat accepted at cycle N appears on `VGA_RGB` at N+1.
- The FSM transitions on the clock edge following its decision cycle.
- Reset values:
  - `hcount` = `vcount` = 0
  - `VGA_HS` = `VGA_VS` = !SYNC_POL
  - `VGA_BLK` = 0, `VGA_RGB` = 0
  - `frame_start` = 0, `locked` = 0, `underflow` = 0
  - `pix_ready` = 0 while `rst` = 1
- Reset mid-frame restarts the raster at (0,0) and enters WAIT_SOF; any partially consumed frame is abandoned.
- With continuous valid input in RUN, exactly H_ACTIVE×V_ACTIVE beats (307200) are consumed per frame.

## Configuration
- `VGA_TEST_PATTERN_EN` defined: fill pixels are 8 vertical colour bars, each H_ACTIVE/8 wide. Order: white, yellow, cyan, green, magenta, red, blue, black; bar index = `hcount[..]` / 80.
- Not defined: fill is 24'h000000.
- Handshake, FSM and flag behaviour are identical in both builds.

## Structure
- Shared package `vga_pkg` holds:
  - FSM state enum `vga_sched_state_t`
  - default 640×480@60 timing constants
  - colour bar RGB constants
- One sub-module, `vga_timing_gen`, contains the counters, the active decode, the sync decode and the `frame_start` decode. `vga_stream_sched` holds the FSM, the handshake, the fill mux and the output registers.

## Test plan
- Reset, then SOF beat presented with valid held high from cycle 0 → `locked` rises when the raster passes (799,524); first `VGA_RGB` equals the SOF beat's data one cycle after (0,0); 307200 beats consumed per frame; `underflow` stays 0.
- Drop `pix_valid` for one cycle at (100,200) in RUN → fill pixel output at that position; `underflow` = 1; `locked` = 0; re-locks at the next frame boundary given a valid SOF.
- SOF beat inserted mid-frame at (10,5) → beat dropped, `underflow` set, RESYNC entered.
- Pulse `rst` at (320,240) → next cycle all outputs hold their reset values; `hcount`/`vcount` = 0/0; state WAIT_SOF.
- Assert `err_clr` in the same cycle as a new underflow → `underflow` remains 1; `err_clr` alone on the next cycle → 0.
- Sync check: `VGA_HS` low for `hcount` 657..752 (registered) and `VGA_VS` low on lines 490–491. Build with `VGA_TEST_PATTERN_EN` and no stream: pixel (85,0) = 24'hFFFF00.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA stream scheduler:
//   - vga_sched_state_t : scheduler FSM states
//   - DEF_*             : default 640x480@60 raster timing
//   - RGB_*             : colour-bar palette used for fill pixels in the
//                         test-pattern build (VGA_TEST_PATTERN_EN)
//   - bar_colour()      : maps a bar index 0..7 to its RGB888 value
package vga_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        RUN      = 2'd1,
        RESYNC   = 2'd2
    } vga_sched_state_t;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    // Bars run left to right in the classic SMPTE-like order.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = RGB_WHITE;
            3'd1:    rgb = RGB_YELLOW;
            3'd2:    rgb = RGB_CYAN;
            3'd3:    rgb = RGB_GREEN;
            3'd4:    rgb = RGB_MAGENTA;
            3'd5:    rgb = RGB_RED;
            3'd6:    rgb = RGB_BLUE;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster counters plus combinational decodes of the current position.
// All decode outputs describe the *current* counter values; the parent
// registers them to produce the pin-level signals one cycle later.
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   hcount, vcount   raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   active           position lies in the visible area
//   hs_active        position lies in the horizontal sync pulse
//   vs_active        position lies in the vertical sync pulse
//   at_origin        position is (0,0)
//   at_last          position is (H_TOTAL-1, V_TOTAL-1)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        srst,
    output logic [11:0] hcount,
    output logic [11:0] vcount,
    output logic        active,
    output logic        hs_active,
    output logic        vs_active,
    output logic        at_origin,
    output logic        at_last
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [11:0] hcount_reg, hcount_next;
    logic [11:0] vcount_reg, vcount_next;
    logic        h_wrap, v_wrap;

    assign h_wrap = (hcount_reg == 12'(H_TOTAL - 1));
    assign v_wrap = (vcount_reg == 12'(V_TOTAL - 1));

    always_comb begin
        hcount_next = hcount_reg + 12'd1;
        vcount_next = vcount_reg;
        if (h_wrap) begin
            hcount_next = '0;
            vcount_next = v_wrap ? '0 : vcount_reg + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
        end
    end

    assign hcount    = hcount_reg;
    assign vcount    = vcount_reg;
    assign active    = (hcount_reg < 12'(H_ACTIVE)) && (vcount_reg < 12'(V_ACTIVE));
    assign hs_active = (hcount_reg >= 12'(HS_FIRST)) && (hcount_reg <= 12'(HS_LAST));
    assign vs_active = (vcount_reg >= 12'(VS_FIRST)) && (vcount_reg <= 12'(VS_LAST));
    assign at_origin = (hcount_reg == 12'd0) && (vcount_reg == 12'd0);
    assign at_last   = h_wrap && v_wrap;

endmodule

// File: rtl/vga_stream_sched.sv
// vga_stream_sched
// Locks a valid/ready RGB888 pixel stream to a VGA raster. One beat is
// pulled per active-area cycle while locked; on a missing beat or an SOF
// that arrives off the frame origin, fill pixels are emitted and the
// scheduler waits for the next frame boundary to re-lock.
// Ports:
//   sys_clk, rst            pixel clock, synchronous active-high reset
//   pix_data/sof/valid      incoming stream beat
//   pix_ready               beat consumed when pix_valid && pix_ready
//   err_clr                 clears the sticky underflow flag
//   hcount, vcount          raster position
//   VGA_HS, VGA_VS          sync outputs (asserted level SYNC_POL)
//   VGA_BLK                 1 = active video
//   VGA_RGB                 pixel output, 0 outside the active area
//   frame_start             one-cycle pulse for raster (0,0)
//   locked                  high while the stream is locked (RUN)
//   underflow               sticky error flag
// Build option: define VGA_TEST_PATTERN_EN to make fill pixels eight
// vertical colour bars instead of black.
module vga_stream_sched
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [23:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        err_clr,
    output logic [11:0] hcount,
    output logic [11:0] vcount,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLK,
    output logic [23:0] VGA_RGB,
    output logic        frame_start,
    output logic        locked,
    output logic        underflow
);

    logic active, hs_active, vs_active, at_origin, at_last;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (sys_clk),
        .srst      (rst),
        .hcount    (hcount),
        .vcount    (vcount),
        .active    (active),
        .hs_active (hs_active),
        .vs_active (vs_active),
        .at_origin (at_origin),
        .at_last   (at_last)
    );

    // ------------------------------------------------------------------
    // Fill pixel for the current position
    // ------------------------------------------------------------------
    logic [23:0] fill_rgb;

`ifdef VGA_TEST_PATTERN_EN
    // Bar width is H_ACTIVE/8; only evaluated inside the active area, where
    // the quotient stays within 0..7 for widths that divide evenly.
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    assign fill_rgb = bar_colour(3'(hcount / 12'(BAR_W)));
`else
    assign fill_rgb = 24'h000000;
`endif

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    vga_sched_state_t state_reg, state_next;
    logic             ready_int;
    logic             use_stream;
    logic             set_underflow;

    always_comb begin
        state_next    = state_reg;
        ready_int     = 1'b0;
        use_stream    = 1'b0;
        set_underflow = 1'b0;
        case (state_reg)
            RUN: begin
                // Pull unconditionally in the active area; a missing beat is
                // detected from pix_valid but never gates ready.
                ready_int = active;
                if (active) begin
                    if (!pix_valid) begin
                        set_underflow = 1'b1;
                        state_next    = RESYNC;
                    end else if (pix_sof && !at_origin) begin
                        // Misaligned frame start: the beat is consumed and dropped.
                        set_underflow = 1'b1;
                        state_next    = RESYNC;
                    end else begin
                        use_stream = 1'b1;
                    end
                end
            end
            WAIT_SOF, RESYNC: begin
                // Flush non-SOF beats; hold an SOF beat at the head until the
                // raster reaches the last position of the frame.
                ready_int = pix_valid && !pix_sof;
                if (at_last && pix_valid && pix_sof) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = WAIT_SOF;
            end
        endcase
    end

    assign pix_ready = ready_int && !rst;
    assign locked    = (state_reg == RUN);

    // ------------------------------------------------------------------
    // Output registers (one cycle behind the counters)
    // ------------------------------------------------------------------
    logic        hs_reg, vs_reg, blk_reg, fs_reg, underflow_reg;
    logic [23:0] rgb_reg, rgb_next;
    logic        underflow_next;

    always_comb begin
        rgb_next = 24'h000000;
        if (active) begin
            rgb_next = use_stream ? pix_data : fill_rgb;
        end
    end

    // A new error in the same cycle as err_clr must survive.
    always_comb begin
        underflow_next = underflow_reg;
        if (set_underflow) begin
            underflow_next = 1'b1;
        end else if (err_clr) begin
            underflow_next = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg     <= WAIT_SOF;
            hs_reg        <= ~SYNC_POL;
            vs_reg        <= ~SYNC_POL;
            blk_reg       <= 1'b0;
            rgb_reg       <= 24'h000000;
            fs_reg        <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hs_reg        <= hs_active ? SYNC_POL : ~SYNC_POL;
            vs_reg        <= vs_active ? SYNC_POL : ~SYNC_POL;
            blk_reg       <= active;
            rgb_reg       <= rgb_next;
            fs_reg        <= at_origin;
            underflow_reg <= underflow_next;
        end
    end

    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLK     = blk_reg;
    assign VGA_RGB     = rgb_reg;
    assign frame_start = fs_reg;
    assign underflow   = underflow_reg;

endmodule
